// File: rtl/tlb_ptw_bus_unit.sv
// tlb_ptw_bus_unit
//   Page-table-walk bus unit serving a TLB. Performs SV39/SV48 translation walks
//   and A/D write-through of a cached PTE. It masters AHB via an arbiter
//   (bus_req/bus_ack) and reports page faults (invalid/misaligned/permission/
//   non-canonical) and access faults (hresp error).
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   satp_ppn, mxr, sum           root table PPN and mstatus bits
//   req_*                        request channel (valid/ready handshake)
//   resp_*                       one-cycle completion pulse and held result
//   haddr..hwdata, hready..hrdata AHB master interface
//   bus_req, bus_ack             arbiter handshake
module tlb_ptw_bus_unit #(
  parameter int unsigned LEVELS = 3,
  parameter int unsigned PPN_W  = 44
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PPN_W-1:0] satp_ppn,
  input  logic             mxr,
  input  logic             sum,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [63:0]      req_va,
  input  logic [63:0]      req_pte,
  input  logic             req_read,
  input  logic             req_write,
  input  logic             req_exec,
  input  logic [3:0]       req_priv,
  output logic             resp_valid,
  output logic [PPN_W-1:0] resp_ppn,
  output logic [63:0]      resp_pte,
  output logic [63:0]      resp_pte_pa,
  output logic [1:0]       resp_level,
  output logic             resp_page_fault,
  output logic             resp_access_fault,
  output logic [63:0]      haddr,
  output logic             hwrite,
  output logic [3:0]       hsize,
  output logic [2:0]       hburst,
  output logic [3:0]       hprot,
  output logic [1:0]       htrans,
  output logic             hmastlock,
  output logic [63:0]      hwdata,
  input  logic             hready,
  input  logic             hresp,
  input  logic [63:0]      hrdata,
  output logic             bus_req,
  input  logic             bus_ack
);

  localparam int unsigned VA_W = 12 + 9 * LEVELS;

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_RD_A, S_RD_D, S_CHK, S_UPD_A, S_UPD_D, S_DONE, S_PF, S_AF
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       lvl_q, lvl_d;
  logic             op_q, op_d;
  logic [63:0]      va_q, va_d;
  logic             rd_q, rd_d, wr_q, wr_d, ex_q, ex_d;
  logic             priv_u_q, priv_u_d, priv_s_q, priv_s_d, priv_m_q, priv_m_d;
  logic [PPN_W-1:0] root_q, root_d;
  logic [63:0]      addr_q, addr_d;
  logic [63:0]      pte_q, pte_d;
  logic [63:0]      pte_pa_q, pte_pa_d;

  logic [PPN_W-1:0] resp_ppn_q, resp_ppn_d;
  logic [63:0]      resp_pte_q, resp_pte_d;
  logic [63:0]      resp_pa_q, resp_pa_d;
  logic [1:0]       resp_lvl_q, resp_lvl_d;
  logic             resp_pf_q, resp_pf_d, resp_af_q, resp_af_d;

  // Reserved privilege encoding bit carries no meaning here.
  logic priv_unused;
  assign priv_unused = req_priv[2];

  function automatic logic [8:0] vpn_of(input logic [63:0] va, input logic [1:0] l);
    logic [63:0] sh;
    sh = va >> (32'd12 + 32'd9 * 32'(l));
    return sh[8:0];
  endfunction

  function automatic logic [63:0] tbl_addr(input logic [PPN_W-1:0] ppn, input logic [8:0] vpn);
    logic [63:0] a;
    a = '0;
    a[PPN_W+11:0] = {ppn, vpn, 3'b000};
    return a;
  endfunction

  function automatic logic is_term(input state_e s);
    return (s == S_DONE) || (s == S_PF) || (s == S_AF);
  endfunction

  // PTE field decode of the most recently fetched / updated PTE.
  logic             pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_dirty;
  logic [PPN_W-1:0] pte_ppn, lvl_mask, merged_ppn;
  logic             is_leaf, misaligned, struct_fault, perm_ok, canonical;

  assign pte_v     = pte_q[0];
  assign pte_r     = pte_q[1];
  assign pte_w     = pte_q[2];
  assign pte_x     = pte_q[3];
  assign pte_u     = pte_q[4];
  assign pte_a     = pte_q[6];
  assign pte_dirty = pte_q[7];
  assign pte_ppn   = pte_q[10 +: PPN_W];

  // Low PPN bits that a superpage at the current level must leave zero,
  // and that are replaced by VA bits in the translated PPN.
  always_comb begin
    lvl_mask = '0;
    for (int unsigned i = 0; i < PPN_W; i++) begin
      if (i < 32'd9 * 32'(lvl_q)) lvl_mask[i] = 1'b1;
    end
  end

  assign merged_ppn   = (pte_ppn & ~lvl_mask) | (va_q[12 +: PPN_W] & lvl_mask);
  assign is_leaf      = pte_r | pte_x;
  assign misaligned   = is_leaf && (lvl_q != 2'd0) && (|(pte_ppn & lvl_mask));
  assign struct_fault = !pte_v || (pte_w && !pte_r) || (!is_leaf && (lvl_q == 2'd0)) ||
                        misaligned;
  assign canonical    = (va_q[63:VA_W-1] == '0) || (&va_q[63:VA_W-1]);

  always_comb begin
    perm_ok = 1'b1;
    if (!priv_m_q) begin
      if (pte_u && priv_s_q && (!sum || ex_q)) perm_ok = 1'b0;
      if (!pte_u && priv_u_q)                  perm_ok = 1'b0;
      if (rd_q && !(pte_r || (mxr && pte_x)))  perm_ok = 1'b0;
      if (wr_q && !pte_w)                      perm_ok = 1'b0;
      if (ex_q && !pte_x)                      perm_ok = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    op_d       = op_q;
    va_d       = va_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    ex_d       = ex_q;
    priv_u_d   = priv_u_q;
    priv_s_d   = priv_s_q;
    priv_m_d   = priv_m_q;
    root_d     = root_q;
    addr_d     = addr_q;
    pte_d      = pte_q;
    pte_pa_d   = pte_pa_q;
    resp_ppn_d = resp_ppn_q;
    resp_pte_d = resp_pte_q;
    resp_pa_d  = resp_pa_q;
    resp_lvl_d = resp_lvl_q;
    resp_pf_d  = resp_pf_q;
    resp_af_d  = resp_af_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d  = S_ARB;
          op_d     = req_op;
          va_d     = req_va;
          rd_d     = req_read;
          wr_d     = req_write;
          ex_d     = req_exec;
          priv_u_d = req_priv[0];
          priv_s_d = req_priv[1];
          priv_m_d = req_priv[3];
          root_d   = satp_ppn;
          lvl_d    = 2'(LEVELS - 1);
          pte_d    = req_op ? (req_pte | 64'hC0) : '0;
          pte_pa_d = '0;
        end
      end
      S_ARB: begin
        if (op_q) begin
          // Write-through: req_va carries the PTE physical address.
          if (bus_ack) begin
            addr_d   = va_q;
            pte_pa_d = va_q;
            lvl_d    = '0;
            state_d  = S_UPD_A;
          end
        end else if (!canonical) begin
          state_d = S_PF;
        end else if (bus_ack) begin
          addr_d  = tbl_addr(root_q, vpn_of(va_q, lvl_q));
          state_d = S_RD_A;
        end
      end
      S_RD_A: state_d = S_RD_D;
      S_RD_D: begin
        if (hresp) begin
          state_d = S_AF;
        end else if (hready) begin
          pte_d    = hrdata;
          pte_pa_d = addr_q;
          state_d  = S_CHK;
        end
      end
      S_CHK: begin
        if (struct_fault) begin
          state_d = S_PF;
        end else if (!is_leaf) begin
          lvl_d   = lvl_q - 2'd1;
          addr_d  = tbl_addr(pte_ppn, vpn_of(va_q, lvl_q - 2'd1));
          state_d = S_RD_A;
        end else if (!perm_ok) begin
          state_d = S_PF;
        end else if (!pte_a || (wr_q && !pte_dirty)) begin
          pte_d   = pte_q | 64'h40 | (wr_q ? 64'h80 : 64'h0);
          addr_d  = pte_pa_q;
          state_d = S_UPD_A;
        end else begin
          state_d = S_DONE;
        end
      end
      S_UPD_A: state_d = S_UPD_D;
      S_UPD_D: begin
        if (hresp)       state_d = S_AF;
        else if (hready) state_d = S_DONE;
      end
      S_DONE, S_PF, S_AF: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Result registers load once, on entry to a terminal state, so they stay
    // stable through the response pulse and while idle afterwards.
    if (is_term(state_d) && !is_term(state_q)) begin
      resp_ppn_d = merged_ppn;
      resp_pte_d = pte_q;
      resp_pa_d  = pte_pa_q;
      resp_lvl_d = lvl_q;
      resp_pf_d  = (state_d == S_PF);
      resp_af_d  = (state_d == S_AF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lvl_q      <= 2'(LEVELS - 1);
      op_q       <= 1'b0;
      va_q       <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ex_q       <= 1'b0;
      priv_u_q   <= 1'b0;
      priv_s_q   <= 1'b0;
      priv_m_q   <= 1'b0;
      root_q     <= '0;
      addr_q     <= '0;
      pte_q      <= '0;
      pte_pa_q   <= '0;
      resp_ppn_q <= '0;
      resp_pte_q <= '0;
      resp_pa_q  <= '0;
      resp_lvl_q <= '0;
      resp_pf_q  <= 1'b0;
      resp_af_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      op_q       <= op_d;
      va_q       <= va_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      ex_q       <= ex_d;
      priv_u_q   <= priv_u_d;
      priv_s_q   <= priv_s_d;
      priv_m_q   <= priv_m_d;
      root_q     <= root_d;
      addr_q     <= addr_d;
      pte_q      <= pte_d;
      pte_pa_q   <= pte_pa_d;
      resp_ppn_q <= resp_ppn_d;
      resp_pte_q <= resp_pte_d;
      resp_pa_q  <= resp_pa_d;
      resp_lvl_q <= resp_lvl_d;
      resp_pf_q  <= resp_pf_d;
      resp_af_q  <= resp_af_d;
    end
  end

  assign req_ready         = (state_q == S_IDLE);
  assign resp_valid        = is_term(state_q);
  assign resp_ppn          = resp_ppn_q;
  assign resp_pte          = resp_pte_q;
  assign resp_pte_pa       = resp_pa_q;
  assign resp_level        = resp_lvl_q;
  assign resp_page_fault   = resp_pf_q;
  assign resp_access_fault = resp_af_q;

  assign bus_req   = (state_q != S_IDLE);
  assign haddr     = addr_q;
  assign htrans    = ((state_q == S_RD_A) || (state_q == S_UPD_A)) ? 2'b10 : 2'b00;
  assign hwrite    = (state_q == S_UPD_A);
  // Write data follows its address phase by one cycle.
  assign hwdata    = (state_q == S_UPD_D) ? pte_q : '0;
  assign hsize     = 4'b0011;
  assign hburst    = 3'b000;
  assign hprot     = 4'b0011;
  assign hmastlock = 1'b0;

endmodule

// File: tb/tb_tlb_ptw_bus_unit.sv
module tb_tlb_ptw_bus_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mxr, sum, req_valid, req_op, req_read, req_write, req_exec, sel4;
  logic [43:0] satp_ppn;
  logic [63:0] req_va, req_pte;
  logic [3:0]  req_priv;
  logic        hready, hresp, bus_ack;
  logic [63:0] hrdata;

  // Per-instance outputs: [0] is LEVELS=3, [1] is LEVELS=4.
  logic        req_ready_w [2], resp_valid_w [2], pf_w [2], af_w [2];
  logic [43:0] resp_ppn_w [2];
  logic [63:0] resp_pte_w [2], resp_pa_w [2], haddr_w [2], hwdata_w [2];
  logic [1:0]  resp_level_w [2], htrans_w [2];
  logic        hwrite_w [2], hmastlock_w [2], bus_req_w [2];
  logic [3:0]  hsize_w [2], hprot_w [2];
  logic [2:0]  hburst_w [2];

  tlb_ptw_bus_unit #(.LEVELS(3), .PPN_W(44)) u_dut3 (
    .clk(clk), .rst(rst), .satp_ppn(satp_ppn), .mxr(mxr), .sum(sum),
    .req_valid(req_valid && !sel4), .req_ready(req_ready_w[0]), .req_op(req_op),
    .req_va(req_va), .req_pte(req_pte), .req_read(req_read), .req_write(req_write),
    .req_exec(req_exec), .req_priv(req_priv), .resp_valid(resp_valid_w[0]),
    .resp_ppn(resp_ppn_w[0]), .resp_pte(resp_pte_w[0]), .resp_pte_pa(resp_pa_w[0]),
    .resp_level(resp_level_w[0]), .resp_page_fault(pf_w[0]), .resp_access_fault(af_w[0]),
    .haddr(haddr_w[0]), .hwrite(hwrite_w[0]), .hsize(hsize_w[0]), .hburst(hburst_w[0]),
    .hprot(hprot_w[0]), .htrans(htrans_w[0]), .hmastlock(hmastlock_w[0]),
    .hwdata(hwdata_w[0]), .hready(hready), .hresp(hresp), .hrdata(hrdata),
    .bus_req(bus_req_w[0]), .bus_ack(bus_ack)
  );

  tlb_ptw_bus_unit #(.LEVELS(4), .PPN_W(44)) u_dut4 (
    .clk(clk), .rst(rst), .satp_ppn(satp_ppn), .mxr(mxr), .sum(sum),
    .req_valid(req_valid && sel4), .req_ready(req_ready_w[1]), .req_op(req_op),
    .req_va(req_va), .req_pte(req_pte), .req_read(req_read), .req_write(req_write),
    .req_exec(req_exec), .req_priv(req_priv), .resp_valid(resp_valid_w[1]),
    .resp_ppn(resp_ppn_w[1]), .resp_pte(resp_pte_w[1]), .resp_pte_pa(resp_pa_w[1]),
    .resp_level(resp_level_w[1]), .resp_page_fault(pf_w[1]), .resp_access_fault(af_w[1]),
    .haddr(haddr_w[1]), .hwrite(hwrite_w[1]), .hsize(hsize_w[1]), .hburst(hburst_w[1]),
    .hprot(hprot_w[1]), .htrans(htrans_w[1]), .hmastlock(hmastlock_w[1]),
    .hwdata(hwdata_w[1]), .hready(hready), .hresp(hresp), .hrdata(hrdata),
    .bus_req(bus_req_w[1]), .bus_ack(bus_ack)
  );

  // Selected instance view.
  logic        m_req_ready, m_resp_valid, m_pf, m_af, m_hwrite, m_hmastlock, m_bus_req;
  logic [43:0] m_resp_ppn;
  logic [63:0] m_resp_pte, m_resp_pa, m_haddr, m_hwdata;
  logic [1:0]  m_resp_level, m_htrans;
  logic [3:0]  m_hsize, m_hprot;
  logic [2:0]  m_hburst;
  assign m_req_ready  = req_ready_w[sel4];
  assign m_resp_valid = resp_valid_w[sel4];
  assign m_pf         = pf_w[sel4];
  assign m_af         = af_w[sel4];
  assign m_resp_ppn   = resp_ppn_w[sel4];
  assign m_resp_pte   = resp_pte_w[sel4];
  assign m_resp_pa    = resp_pa_w[sel4];
  assign m_resp_level = resp_level_w[sel4];
  assign m_haddr      = haddr_w[sel4];
  assign m_hwdata     = hwdata_w[sel4];
  assign m_hwrite     = hwrite_w[sel4];
  assign m_htrans     = htrans_w[sel4];
  assign m_hsize      = hsize_w[sel4];
  assign m_hprot      = hprot_w[sel4];
  assign m_hburst     = hburst_w[sel4];
  assign m_hmastlock  = hmastlock_w[sel4];
  assign m_bus_req    = bus_req_w[sel4];

  // AHB slave model: table memory indexed by {PPN[1:0], VPN[5:0]}, optional
  // single wait state per transfer, optional error on the Nth read.
  logic [63:0] mem [256];
  logic        dp_valid, dp_write, dp_wait, ws_en, clr;
  logic [63:0] dp_addr, wr_addr, wr_data;
  logic [63:0] rd_log [8];
  int          dp_rdidx, n_rd, n_wr, bad_ctrl, err_rd;

  assign hready = !(dp_valid && dp_wait);
  assign hresp  = dp_valid && hready && !dp_write && (dp_rdidx == err_rd);
  assign hrdata = (dp_valid && !dp_write) ? mem[{dp_addr[13:12], dp_addr[8:3]}] : 64'h0;

  always @(posedge clk) begin
    if (rst || clr) begin
      dp_valid <= 1'b0; dp_wait <= 1'b0; dp_write <= 1'b0; dp_addr <= '0; dp_rdidx <= 0;
      n_rd <= 0; n_wr <= 0; bad_ctrl <= 0; wr_addr <= '0; wr_data <= '0;
    end else begin
      if (dp_valid && !hready) begin
        dp_wait <= 1'b0;
      end else begin
        dp_valid <= (m_htrans == 2'b10);
        dp_addr  <= m_haddr;
        dp_write <= m_hwrite;
        dp_wait  <= (m_htrans == 2'b10) && ws_en;
        dp_rdidx <= n_rd;
        if (m_htrans == 2'b10) begin
          if (m_hwrite) n_wr <= n_wr + 1;
          else begin
            rd_log[n_rd % 8] <= m_haddr;
            n_rd <= n_rd + 1;
          end
          if (m_hsize != 4'b0011 || m_hburst != 3'b000 || m_hprot != 4'b0011 || m_hmastlock)
            bad_ctrl <= bad_ctrl + 1;
        end
      end
      if (dp_valid && hready && dp_write) begin
        wr_addr <= dp_addr;
        wr_data <= m_hwdata;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pa(input logic [43:0] ppn, input logic [8:0] vpn);
    return {8'h00, ppn, vpn, 3'b000};
  endfunction

  task automatic set_pte(input logic [43:0] ppn, input logic [8:0] vpn, input logic [63:0] v);
    mem[{ppn[1:0], vpn[5:0]}] = v;
  endtask

  logic        got;
  logic [43:0] c_ppn;
  logic [63:0] c_pte, c_pa;
  logic [1:0]  c_lvl;
  logic        c_pf, c_af;

  // rwx = {read, write, exec}
  task automatic run_req(input logic op, input logic [63:0] va, input logic [63:0] pte,
                         input logic [2:0] rwx, input logic [3:0] priv);
    int cyc;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    req_op = op; req_va = va; req_pte = pte; {req_read, req_write, req_exec} = rwx;
    req_priv = priv; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; req_va = '1; req_pte = '1; req_op = ~op;
    @(negedge clk);
    check_eq("bus_req_held", 64'(m_bus_req), 64'd1);
    got = 1'b0; cyc = 0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (m_resp_valid) begin
        got = 1'b1;
        c_ppn = m_resp_ppn; c_pte = m_resp_pte; c_pa = m_resp_pa;
        c_lvl = m_resp_level; c_pf = m_pf; c_af = m_af;
      end
    end
    check_eq("resp_seen", 64'(got), 64'd1);
    if (got) begin
      @(negedge clk);
      check_eq("resp_one_cycle", 64'(m_resp_valid), 64'd0);
      check_eq("ready_after", 64'(m_req_ready), 64'd1);
      check_eq("resp_stable", m_resp_pte, c_pte);
    end
  endtask

  initial begin
    int cyc;
    logic seen;
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_va = '0; req_pte = '0;
    req_read = 1'b0; req_write = 1'b0; req_exec = 1'b0; req_priv = 4'b0010;
    sel4 = 1'b0; ws_en = 1'b0; err_rd = -1; clr = 1'b0; bus_ack = 1'b1;
    satp_ppn = 44'h100; mxr = 1'b0; sum = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 64'(m_req_ready), 64'd1);
    check_eq("rst_resp_valid", 64'(m_resp_valid), 64'd0);
    check_eq("rst_htrans", 64'(m_htrans), 64'd0);
    check_eq("rst_hwrite", 64'(m_hwrite), 64'd0);
    check_eq("rst_bus_req", 64'(m_bus_req), 64'd0);
    check_eq("rst_resp_lvl", 64'(m_resp_level), 64'd0);
    check_eq("rst_resp_pte", m_resp_pte, 64'd0);

    // 4K walk with a wait state on every transfer.
    set_pte(44'h100, 9'd1, 64'h40401);
    set_pte(44'h101, 9'd2, 64'h40801);
    set_pte(44'h102, 9'd3, 64'h48D14CF);
    ws_en = 1'b1;
    run_req(1'b0, 64'h40403123, 64'h0, 3'b100, 4'b0010);
    ws_en = 1'b0;
    check_eq("4k_nrd", 64'(n_rd), 64'd3);
    check_eq("4k_nwr", 64'(n_wr), 64'd0);
    check_eq("4k_rd0", rd_log[0], pa(44'h100, 9'd1));
    check_eq("4k_rd1", rd_log[1], pa(44'h101, 9'd2));
    check_eq("4k_rd2", rd_log[2], pa(44'h102, 9'd3));
    check_eq("4k_lvl", 64'(c_lvl), 64'd0);
    check_eq("4k_ppn", 64'(c_ppn), 64'h12345);
    check_eq("4k_pf", 64'(c_pf), 64'd0);
    check_eq("4k_af", 64'(c_af), 64'd0);
    check_eq("4k_pte", c_pte, 64'h48D14CF);
    check_eq("4k_pa", c_pa, 64'h102018);
    check_eq("4k_ctrl", 64'(bad_ctrl), 64'd0);

    // 2M superpage, aligned.
    set_pte(44'h101, 9'd2, 64'h800CF);
    run_req(1'b0, 64'h40403123, 64'h0, 3'b100, 4'b0010);
    check_eq("2m_nrd", 64'(n_rd), 64'd2);
    check_eq("2m_lvl", 64'(c_lvl), 64'd1);
    check_eq("2m_ppn", 64'(c_ppn), 64'h203);
    check_eq("2m_pf", 64'(c_pf), 64'd0);
    check_eq("2m_pa", c_pa, 64'h101010);

    // 2M superpage, misaligned PPN[0]=1.
    set_pte(44'h101, 9'd2, 64'h804CF);
    run_req(1'b0, 64'h40403123, 64'h0, 3'b100, 4'b0010);
    check_eq("2m_mis_pf", 64'(c_pf), 64'd1);
    check_eq("2m_mis_af", 64'(c_af), 64'd0);
    check_eq("2m_mis_pte", c_pte, 64'h804CF);
    check_eq("2m_mis_nwr", 64'(n_wr), 64'd0);

    // Store to a leaf with A=1, D=0: D must be written back.
    set_pte(44'h101, 9'd2, 64'h40801);
    set_pte(44'h102, 9'd3, 64'h48D1447);
    run_req(1'b0, 64'h40403123, 64'h0, 3'b010, 4'b0010);
    check_eq("wd_nrd", 64'(n_rd), 64'd3);
    check_eq("wd_nwr", 64'(n_wr), 64'd1);
    check_eq("wd_waddr", wr_addr, 64'h102018);
    check_eq("wd_wdata", wr_data, 64'h48D14C7);
    check_eq("wd_pf", 64'(c_pf), 64'd0);
    check_eq("wd_af", 64'(c_af), 64'd0);
    check_eq("wd_pte", c_pte, 64'h48D14C7);

    // Bus error on the second read.
    set_pte(44'h102, 9'd3, 64'h48D14CF);
    err_rd = 1;
    run_req(1'b0, 64'h40403123, 64'h0, 3'b100, 4'b0010);
    err_rd = -1;
    check_eq("af_af", 64'(c_af), 64'd1);
    check_eq("af_pf", 64'(c_pf), 64'd0);
    check_eq("af_nwr", 64'(n_wr), 64'd0);
    check_eq("af_nrd", 64'(n_rd), 64'd2);
    check_eq("af_pte", c_pte, 64'h40401);

    // Write-through of a cached PTE.
    run_req(1'b1, 64'h102018, 64'h48D1401, 3'b000, 4'b0010);
    check_eq("wt_nrd", 64'(n_rd), 64'd0);
    check_eq("wt_nwr", 64'(n_wr), 64'd1);
    check_eq("wt_waddr", wr_addr, 64'h102018);
    check_eq("wt_wdata", wr_data, 64'h48D14C1);
    check_eq("wt_pte", c_pte, 64'h48D14C1);
    check_eq("wt_pa", c_pa, 64'h102018);
    check_eq("wt_fault", {62'd0, c_pf, c_af}, 64'd0);

    // Non-canonical VA: bit 38 set, bit 63 clear.
    run_req(1'b0, 64'h40_0000_0000, 64'h0, 3'b100, 4'b0010);
    check_eq("nc_pf", 64'(c_pf), 64'd1);
    check_eq("nc_bus", 64'(n_rd + n_wr), 64'd0);

    // U page read from S mode: fault without SUM, allowed with SUM.
    set_pte(44'h102, 9'd3, 64'h48D14DF);
    run_req(1'b0, 64'h40403123, 64'h0, 3'b100, 4'b0010);
    check_eq("upg_nosum_pf", 64'(c_pf), 64'd1);
    sum = 1'b1;
    run_req(1'b0, 64'h40403123, 64'h0, 3'b100, 4'b0010);
    sum = 1'b0;
    check_eq("upg_sum_pf", 64'(c_pf), 64'd0);
    check_eq("upg_sum_ppn", 64'(c_ppn), 64'h12345);

    // SV48: four reads, VPN[3] taken from VA[47:39].
    set_pte(44'h100, 9'd1, 64'h40C01);
    set_pte(44'h103, 9'd1, 64'h40401);
    set_pte(44'h102, 9'd3, 64'h48D14CF);
    sel4 = 1'b1;
    run_req(1'b0, 64'h80_4040_3000, 64'h0, 3'b100, 4'b0010);
    check_eq("sv48_nrd", 64'(n_rd), 64'd4);
    check_eq("sv48_rd0", rd_log[0], pa(44'h100, 9'd1));
    check_eq("sv48_rd1", rd_log[1], pa(44'h103, 9'd1));
    check_eq("sv48_rd3", rd_log[3], pa(44'h102, 9'd3));
    check_eq("sv48_ppn", 64'(c_ppn), 64'h12345);
    check_eq("sv48_lvl", 64'(c_lvl), 64'd0);
    check_eq("sv48_pf", 64'(c_pf), 64'd0);
    sel4 = 1'b0;

    // Reset while the first read's data phase is stalled.
    set_pte(44'h100, 9'd1, 64'h40401);
    ws_en = 1'b1;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    req_op = 1'b0; req_va = 64'h40403123; {req_read, req_write, req_exec} = 3'b100;
    req_priv = 4'b0010; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (m_htrans == 2'b10) seen = 1'b1;
    end
    check_eq("rstw_nseq_seen", 64'(seen), 64'd1);
    @(negedge clk);
    check_eq("rstw_stalled", 64'(hready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ws_en = 1'b0;
    check_eq("rstw_ready", 64'(m_req_ready), 64'd1);
    check_eq("rstw_bus_req", 64'(m_bus_req), 64'd0);
    check_eq("rstw_htrans", 64'(m_htrans), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (m_resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check_eq("rstw_no_resp", 64'(seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
